sram_1r1w_access_ctrl: RTL

//  Request-side controller for the 32x2048 1R1W OpenRAM macro (write port 0, read port 1).
//  - Accepts independent write and read requests over valid/ready channels.
//  - Drives the macro's registered-input pins from flops and captures read data.
//  - Returns read data through a backpressured response FIFO.
//  - Sits between the core/bus adapter and the macro; clk also feeds the macro's clk0/clk1 at top level.

---
 rtl/sram_ctrl_pkg.sv | 27 ++
 rtl/sram_rsp_fifo.sv | 72 +++++++
 rtl/sram_1r1w_access_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared widths, read-request type and helpers for the 32x2048
//               1R1W SRAM access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

  // Macro geometry: 2048 words of 32 bits, byte-lane write masks.
  localparam int C_ADDR_WIDTH = 11;
  localparam int C_DATA_WIDTH = 32;
  localparam int C_NUM_WMASKS = C_DATA_WIDTH / 8;
  localparam int C_RSP_DEPTH  = 4;

  // A read request only needs its word address; the data comes back later.
  typedef struct packed {
    logic [C_ADDR_WIDTH-1:0] addr;
  } rd_req_t;

  // True when a write touches at least one byte lane of the macro.
  function automatic logic lanes_enabled(input logic [C_NUM_WMASKS-1:0] mask);
    return |mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_rsp_fifo
// Description : First-word-fall-through synchronous FIFO holding read data
//               captured from the SRAM macro until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam logic [C_PTR_W:0] C_FULL_CNT = DEPTH[C_PTR_W:0];

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [C_PTR_W-1:0] wr_ptr_q;
  logic [C_PTR_W-1:0] rd_ptr_q;
  logic [C_PTR_W:0]   count_q;

  logic w_pop_ok;
  logic w_push_ok;

  // A pop frees a slot in the same edge, so a push into a full FIFO that is
  // being popped is still taken.
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);

  assign empty = (count_q == '0);
  assign full  = (count_q == C_FULL_CNT);
  assign count = count_q;
  // Head entry is presented directly; storage is cleared on reset so the
  // output never carries anything but zeros or captured words.
  assign dout  = mem_q[rd_ptr_q];

  // Storage, pointers (wrap naturally at power-of-two depth) and occupancy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push_ok) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_1r1w_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_1r1w_access_ctrl
// Description : Request-side controller for a 32x2048 1R1W OpenRAM macro.
//               Write requests drive port 0, read requests drive port 1, and
//               read data returns in order through a credit-managed FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_1r1w_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = C_ADDR_WIDTH,
  parameter int DATA_WIDTH = C_DATA_WIDTH,
  parameter int NUM_WMASKS = C_NUM_WMASKS,
  parameter int RSP_DEPTH  = C_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  // write request channel
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_WMASKS-1:0] wr_mask,
  // read request channel
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  // read response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  // macro port 0 (write)
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  // macro port 1 (read)
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int C_CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam logic [C_CNT_W:0] C_DEPTH_LIM = RSP_DEPTH[C_CNT_W:0];

  // Issue flops feeding the macro's registered-input pins.
  logic                  csb0_q,   csb0_d;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_q,  addr0_d;
  logic [DATA_WIDTH-1:0] din0_q,   din0_d;
  logic                  csb1_q,   csb1_d;
  rd_req_t               rd_req_q, rd_req_d;

  // Bit 0: read issued last edge (macro samples next edge).
  // Bit 1: read sampled by the macro; dout1 is valid for capture this edge.
  logic [1:0]            inflight_q, inflight_d;

  logic                  w_wr_access;
  logic                  w_collision;
  logic                  w_credit_ok;
  logic                  w_rd_fire;
  logic [1:0]            w_inflight_n;
  logic [C_CNT_W:0]      w_credits_used;
  logic [C_CNT_W-1:0]    w_fifo_count;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;

  // Writes never stall; mask==0 is accepted but does not select the macro.
  assign wr_ready    = nrst;
  assign w_wr_access = wr_valid & lanes_enabled(wr_mask);

  // A same-cycle read of the address being written is held back one cycle so
  // the macro has already committed the new word when the read is sampled.
  assign w_collision = wr_valid & rd_valid & (wr_addr == rd_addr);

  // Every issued read owns a FIFO slot from issue until it is popped, so the
  // FIFO can never be asked to hold more than RSP_DEPTH words.
  assign w_inflight_n   = {1'b0, inflight_q[0]} + {1'b0, inflight_q[1]};
  assign w_credits_used = {1'b0, w_fifo_count} + {{(C_CNT_W-1){1'b0}}, w_inflight_n};
  // The full term is implied by the credit count; it keeps the guard local.
  assign w_credit_ok    = (w_credits_used < C_DEPTH_LIM) & ~w_fifo_full;

  assign rd_ready  = nrst & ~w_collision & w_credit_ok;
  assign w_rd_fire = rd_valid & rd_ready;

  // Next-state for the macro pins: select on a request, otherwise deselect
  // and hold address/data/mask so idle cycles do not toggle the buses.
  always_comb begin
    csb0_d     = 1'b1;
    wmask0_d   = wmask0_q;
    addr0_d    = addr0_q;
    din0_d     = din0_q;
    csb1_d     = 1'b1;
    rd_req_d   = rd_req_q;
    inflight_d = {inflight_q[0], w_rd_fire};
    if (w_wr_access) begin
      csb0_d   = 1'b0;
      wmask0_d = wr_mask;
      addr0_d  = wr_addr;
      din0_d   = wr_data;
    end
    if (w_rd_fire) begin
      csb1_d        = 1'b0;
      rd_req_d.addr = rd_addr;
    end
  end

  // Issue registers and in-flight tracking; reset deselects the macro and
  // forgets any read already on its way.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      csb0_q     <= 1'b1;
      wmask0_q   <= '0;
      addr0_q    <= '0;
      din0_q     <= '0;
      csb1_q     <= 1'b1;
      rd_req_q   <= '0;
      inflight_q <= '0;
    end else begin
      csb0_q     <= csb0_d;
      wmask0_q   <= wmask0_d;
      addr0_q    <= addr0_d;
      din0_q     <= din0_d;
      csb1_q     <= csb1_d;
      rd_req_q   <= rd_req_d;
      inflight_q <= inflight_d;
    end
  end

  assign sram_csb0   = csb0_q;
  assign sram_wmask0 = wmask0_q;
  assign sram_addr0  = addr0_q;
  assign sram_din0   = din0_q;
  assign sram_csb1   = csb1_q;
  assign sram_addr1  = rd_req_q.addr;

  // Captures dout1 two edges after issue and returns words in request order.
  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (inflight_q[1]),
    .din   (sram_dout1),
    .pop   (rsp_ready),
    .dout  (rsp_data),
    .count (w_fifo_count),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  assign rsp_valid = ~w_fifo_empty;

endmodule
`default_nettype wire
